segre_lsu: RTL and testbench
============================

SEGRE_LSU -- requirements
Module: segre_lsu

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, width of byte addresses.
REQ-002 SHALL have parameter WORD_SIZE, default 32, width of data words.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rsn_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ex_valid_i  input  1  EX stage presents an operation.
REQ-006 SHALL have port ex_ready_o  output  1  LSU accepts the EX operation this cycle.
REQ-007 SHALL have port memop_rd_i / memop_wr_i  input  1 each  operation is a load / store; both low = pass-through.
REQ-008 SHALL have port memop_type_i  input  2  memop_data_type_e: BYTE, HALF, WORD.
REQ-009 SHALL have port memop_sign_ext_i  input  1  sign-extend load data (LB/LH) when high.
REQ-010 SHALL have port alu_res_i  input  ADDR_SIZE  effective address, or result for pass-through.
REQ-011 SHALL have port wdata_i  input  WORD_SIZE  store data, LSB-aligned.
REQ-012 SHALL have port rd_i  input  REG_SIZE  destination register; rf_we_i  input  1  writeback enable.
REQ-013 SHALL have port mem_req_o  output  1; mem_we_o  output  1; mem_addr_o  output  ADDR_SIZE, bits [1:0] forced 0; mem_be_o  output  4; mem_wdata_o  output  WORD_SIZE.
REQ-014 SHALL have port mem_gnt_i  input  1  request accepted; mem_rvalid_i  input  1  response valid; mem_rdata_i  input  WORD_SIZE.
REQ-015 SHALL have port wb_valid_o  output  1; wb_we_o  output  1; wb_rd_o  output  REG_SIZE; wb_data_o  output  WORD_SIZE.
REQ-016 SHALL have port misaligned_o  output  1  one-cycle pulse on misaligned access.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-018 IDLE: ex_ready_o=1. On ex_valid_i, capture inputs; load/store -> REQ; pass-through -> RESP with wb_data=alu_res_i.
REQ-019 Misalignment SHALL be HALF with addr[0]=1, or WORD with addr[1:0]!=0. Such an op SHALL pulse misaligned_o in the acceptance cycle, issue no memory request, and go to RESP with wb_we_o=0.
REQ-020 REQ: mem_req_o=1 with address, we, be and data held stable until mem_gnt_i; on gnt -> WAIT.
REQ-021 Byte enables SHALL be BYTE 4'b0001<<addr[1:0], HALF 4'b0011<<addr[1:0], WORD 4'b1111.
REQ-022 Store data SHALL be replicated: BYTE {4{wdata[7:0]}}, HALF {2{wdata[15:0]}}, WORD wdata.
REQ-023 WAIT: on mem_rvalid_i, latch the extracted load data -> RESP. A store SHALL also wait for rvalid (write ack).
REQ-024 Load extraction SHALL select the byte/half at addr offset, then zero- or sign-extend it to WORD_SIZE per memop_sign_ext_i.
REQ-025 RESP: wb_valid_o=1 for exactly one cycle; wb_we_o=rf_we && !store && !misaligned; then -> IDLE.
REQ-026 ex_ready_o SHALL be 0 in REQ, WAIT and RESP; at most one outstanding memory transaction.
REQ-027 mem_gnt_i and mem_rvalid_i in the same REQ cycle SHALL be treated as gnt then rvalid: go directly to RESP.
REQ-028 mem_rvalid_i outside WAIT (or that same-cycle REQ case) SHALL be ignored.
REQ-029 Minimum latency: load or store accept -> wb_valid_o = 3 cycles with gnt and rvalid each one cycle late; pass-through = 1 cycle.

Reset
REQ-030 rsn_i low SHALL immediately force state IDLE, mem_req_o=0, wb_valid_o=0, wb_we_o=0, misaligned_o=0, and all data/address registers to 0, regardless of state.
REQ-031 A transaction interrupted by reset SHALL be abandoned; after reset is released, a late mem_rvalid_i SHALL be ignored.

Verification
REQ-032 LW addr 0x100, gnt after 2 cycles, rdata 0xDEADBEEF -> be=1111, addr 0x100, wb_data 0xDEADBEEF, wb_we=1.
REQ-033 LB signed addr 0x103, rdata 0x80xxxxxx -> be=1000, wb_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-034 SH addr 0x102, wdata 0x1234ABCD -> be=1100, mem_wdata 0xABCDABCD, wb_we=0.
REQ-035 LW addr 0x101 -> misaligned_o pulse, no mem_req_o, wb_valid_o=1 with wb_we_o=0.
REQ-036 Reset asserted in WAIT -> outputs zero at once; rvalid after release ignored; next pass-through result 0x5 -> wb_data 0x5.
REQ-037 gnt and rvalid in same cycle -> wb_valid_o next cycle; back-to-back ops accepted every RESP->IDLE.

Source files
------------

// File: rtl/segre_lsu.sv
// -----------------------------------------------------------------------------
// segre_lsu -- load/store unit between the EX stage and a single-port data
// memory. It accepts one operation at a time, issues at most one memory
// transaction, and produces one writeback beat per accepted operation.
//
// Ports
//   clk_i, rsn_i          clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o EX-stage operation handshake
//   memop_rd_i/memop_wr_i load / store select (both low = pass-through)
//   memop_type_i          0 = BYTE, 1 = HALF, 2 = WORD
//   memop_sign_ext_i      sign-extend BYTE/HALF load data
//   alu_res_i             effective address, or the pass-through result
//   wdata_i               store data, LSB-aligned
//   rd_i, rf_we_i         destination register and writeback enable
//   mem_*                 memory request (req/gnt) and response (rvalid/rdata)
//   wb_*                  writeback beat, valid for exactly one cycle
//   misaligned_o          one-cycle pulse for a misaligned load/store
//   state_o               current FSM state (IDLE=0, REQ=1, WAIT=2, RESP=3)
//
// Handshakes: ex_valid_i/ex_ready_o transfer an operation on a rising edge
// where both are high. mem_req_o stays high with stable address, we, be and
// wdata until a rising edge where mem_gnt_i is high. mem_rvalid_i is only
// honoured in WAIT, or together with mem_gnt_i in REQ; a store also waits
// for rvalid as its write acknowledge.
// -----------------------------------------------------------------------------
module segre_lsu #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic [1:0]           memop_type_i,
    input  logic                 memop_sign_ext_i,
    input  logic [ADDR_SIZE-1:0] alu_res_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [REG_SIZE-1:0]  rd_i,
    input  logic                 rf_we_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic                 wb_valid_o,
    output logic                 wb_we_o,
    output logic [REG_SIZE-1:0]  wb_rd_o,
    output logic [WORD_SIZE-1:0] wb_data_o,
    output logic                 misaligned_o,
    output logic [1:0]           state_o
);

    localparam logic [1:0] MT_BYTE = 2'd0;
    localparam logic [1:0] MT_HALF = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e               state_q;
    logic                 ex_ready_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [1:0]           type_q;
    logic                 sign_q;
    logic [REG_SIZE-1:0]  rd_q;
    logic                 rf_we_q;
    logic                 store_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [3:0]           be_q;
    logic [WORD_SIZE-1:0] mem_wdata_q;
    logic                 wb_valid_q;
    logic                 wb_we_q;
    logic [WORD_SIZE-1:0] wb_data_q;
    logic                 misaligned_q;

    // Decode of the operation presented by EX.
    logic                 acc_mem;
    logic                 acc_misaligned;
    logic [3:0]           acc_be;
    logic [WORD_SIZE-1:0] acc_wdata;

    always_comb begin
        acc_mem        = memop_rd_i | memop_wr_i;
        acc_misaligned = 1'b0;
        acc_be         = 4'b1111;
        acc_wdata      = wdata_i;
        case (memop_type_i)
            MT_BYTE: begin
                acc_be    = 4'b0001 << alu_res_i[1:0];
                acc_wdata = {(WORD_SIZE/8){wdata_i[7:0]}};
            end
            MT_HALF: begin
                acc_misaligned = alu_res_i[0];
                acc_be         = 4'b0011 << alu_res_i[1:0];
                acc_wdata      = {(WORD_SIZE/16){wdata_i[15:0]}};
            end
            default: acc_misaligned = |alu_res_i[1:0];
        endcase
    end

    // Load extraction; only aligned accesses reach memory, so a half always
    // sits on lane 0 or lane 2.
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [WORD_SIZE-1:0] ld_data;

    always_comb begin
        byte_sel = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (type_q)
            MT_BYTE: ld_data = {{(WORD_SIZE-8){sign_q & byte_sel[7]}}, byte_sel};
            MT_HALF: ld_data = {{(WORD_SIZE-16){sign_q & half_sel[15]}}, half_sel};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Response completes the transaction; gnt+rvalid together in REQ counts
    // as grant followed immediately by the response.
    logic mem_done;
    assign mem_done = ((state_q == REQ) && mem_gnt_i && mem_rvalid_i) ||
                      ((state_q == WAIT) && mem_rvalid_i);

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= IDLE;
            ex_ready_q   <= 1'b1;
            addr_q       <= '0;
            type_q       <= '0;
            sign_q       <= 1'b0;
            rd_q         <= '0;
            rf_we_q      <= 1'b0;
            store_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            be_q         <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_data_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid_i) begin
                        ex_ready_q <= 1'b0;
                        addr_q     <= alu_res_i;
                        type_q     <= memop_type_i;
                        sign_q     <= memop_sign_ext_i;
                        rd_q       <= rd_i;
                        rf_we_q    <= rf_we_i;
                        store_q    <= memop_wr_i;
                        if (!acc_mem) begin
                            state_q    <= RESP;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= rf_we_i;
                            wb_data_q  <= WORD_SIZE'(alu_res_i);
                        end else if (acc_misaligned) begin
                            // Faulting access: no memory traffic, data reads 0.
                            state_q      <= RESP;
                            wb_valid_q   <= 1'b1;
                            wb_we_q      <= 1'b0;
                            wb_data_q    <= '0;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= memop_wr_i;
                            be_q        <= acc_be;
                            mem_wdata_q <= acc_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: ;
                RESP: begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    ex_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            // Overrides the REQ->WAIT step when the response is already here.
            if (mem_done) begin
                state_q    <= RESP;
                wb_valid_q <= 1'b1;
                wb_we_q    <= rf_we_q & ~store_q;
                wb_data_q  <= store_q ? '0 : ld_data;
            end
        end
    end

    assign ex_ready_o   = ex_ready_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = {addr_q[ADDR_SIZE-1:2], 2'b00};
    assign mem_be_o     = be_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = wb_data_q;
    assign misaligned_o = misaligned_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_segre_lsu.sv
module tb_segre_lsu;

  localparam logic [1:0] T_B = 2'd0;
  localparam logic [1:0] T_H = 2'd1;
  localparam logic [1:0] T_W = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rsn_i = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic        memop_rd_i = 1'b0;
  logic        memop_wr_i = 1'b0;
  logic [1:0]  memop_type_i = 2'd0;
  logic        memop_sign_ext_i = 1'b0;
  logic [31:0] alu_res_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  rd_i = '0;
  logic        rf_we_i = 1'b0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;
  logic [1:0]  state_o;

  segre_lsu #(.ADDR_SIZE(32), .WORD_SIZE(32), .REG_SIZE(5)) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
    .memop_type_i(memop_type_i), .memop_sign_ext_i(memop_sign_ext_i),
    .alu_res_i(alu_res_i), .wdata_i(wdata_i), .rd_i(rd_i), .rf_we_i(rf_we_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misaligned_o(misaligned_o), .state_o(state_o)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          first;
    int          last;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  int   n_wb_exp = 0;
  int   n_wb_done = 0;

  function automatic logic m_mis(input logic [1:0] t, input logic [31:0] a);
    if (t == T_B) return 1'b0;
    if (t == T_H) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] t, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (t == T_B) return 4'(1 << off);
    if (t == T_H) return 4'(3 << off);
    return 4'hF;
  endfunction

  // Lane by lane: each byte lane carries the byte the access size puts there.
  function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (t == T_B) r[8*i +: 8] = w[7:0];
      else if (t == T_H) r[8*i +: 8] = w[8*(i%2) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a,
                                         input logic [1:0] t, input logic sx);
    logic [7:0]  b[4];
    logic [15:0] h;
    int off;
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    off = int'(a[1:0]);
    if (t == T_B) return sx ? 32'($signed(b[off])) : {24'h0, b[off]};
    if (t == T_H) begin
      h = {b[off+1], b[off]};
      return sx ? 32'($signed(h)) : {16'h0, h};
    end
    return rdata;
  endfunction

  // ---------------- compare process ----------------
  logic        req_now, wb_now;
  logic [31:0] last_addr, last_wdata, last_wb_data;
  logic [3:0]  last_be;
  logic        last_wb_we;
  int          last_wb_cyc = 0;
  int          req_cycles = 0;
  int          mis_count = 0;

  always @(negedge clk) begin
    if (rsn_i) begin
      req_now = (exp_req.size() > 0) ? (cyc >= exp_req[0].first && cyc <= exp_req[0].last) : 1'b0;
      check1("mem_req", mem_req_o, req_now);
      if (req_now) begin
        check32("mem_addr", mem_addr_o, exp_req[0].addr);
        check1("mem_we", mem_we_o, exp_req[0].we);
        check32("mem_be", 32'(mem_be_o), 32'(exp_req[0].be));
        if (exp_req[0].we) check32("mem_wdata", mem_wdata_o, exp_req[0].wdata);
        last_addr  = mem_addr_o;
        last_be    = mem_be_o;
        last_wdata = mem_wdata_o;
      end
      if (mem_req_o) req_cycles++;
      if (exp_req.size() > 0) if (cyc >= exp_req[0].last) void'(exp_req.pop_front());

      wb_now = (exp_wb.size() > 0) ? (cyc == exp_wb[0].cyc) : 1'b0;
      check1("ex_ready", ex_ready_o, exp_wb.size() == 0);
      check1("wb_valid", wb_valid_o, wb_now);
      check1("wb_we", wb_we_o, wb_now ? exp_wb[0].we : 1'b0);
      check1("misaligned", misaligned_o, wb_now ? exp_wb[0].mis : 1'b0);
      if (misaligned_o) mis_count++;
      if (wb_now) begin
        check32("wb_rd", 32'(wb_rd_o), 32'(exp_wb[0].rd));
        check32("wb_data", wb_data_o, exp_wb[0].data);
        last_wb_data = wb_data_o;
        last_wb_we   = wb_we_o;
        last_wb_cyc  = cyc;
      end
      if (exp_wb.size() > 0) if (cyc >= exp_wb[0].cyc) begin
        void'(exp_wb.pop_front());
        n_wb_done++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rd, input logic wr, input logic [1:0] t, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rr,
                       input logic we, input int g, input int r, input logic [31:0] rdata,
                       output int e0, output logic go);
    logic rdy, acc, mem, mis;
    req_t q;
    wb_t  w;
    ex_valid_i = 1'b1; memop_rd_i = rd; memop_wr_i = wr; memop_type_i = t;
    memop_sign_ext_i = sx; alu_res_i = a; wdata_i = wd; rd_i = rr; rf_we_i = we;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk); rdy = ex_ready_o;
      @(posedge clk); #1; acc = rdy;
    end
    e0 = cyc;
    ex_valid_i = 1'b0;
    check1("accept", acc, 1'b1);
    mem = rd | wr;
    mis = mem && m_mis(t, a);
    go  = acc && mem && !mis;
    if (!acc) return;
    if (go) begin
      q.first = e0; q.last = e0 + g; q.addr = {a[31:2], 2'b00};
      q.we = wr; q.be = m_be(t, a); q.wdata = m_wdata(t, wd);
      exp_req.push_back(q);
    end
    w.cyc  = go ? e0 + g + r + 1 : e0;
    w.we   = !mem ? we : (we && !wr && !mis);
    w.rd   = rr;
    w.mis  = mis;
    w.data = !mem ? a : ((mis || wr) ? 32'h0 : m_load(rdata, a, t, sx));
    exp_wb.push_back(w);
    n_wb_exp++;
  endtask

  // Memory side: gnt g cycles after the request appears, rvalid r cycles after gnt.
  task automatic respond(input int g, input int r, input logic [31:0] rdata);
    for (int k = 0; k <= g + r; k++) begin
      mem_gnt_i    = (k == g);
      mem_rvalid_i = (k == g + r);
      mem_rdata_i  = (k == g + r) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    while (n_wb_done != n_wb_exp && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check32("wb_done", n_wb_done, n_wb_exp);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] t, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rr,
                    input logic we, input int g, input int r, input logic [31:0] rdata,
                    output int e0);
    logic go;
    issue(rd, wr, t, sx, a, wd, rr, we, g, r, rdata, e0, go);
    if (go) respond(g, r, rdata);
    wait_wb();
  endtask

  // ---------------- stimulus ----------------
  int e0, ea, eb, ec, rc, mc;
  logic go;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check1("rst_ready", ex_ready_o, 1'b1);
    check1("rst_req", mem_req_o, 1'b0);
    check1("rst_wb_valid", wb_valid_o, 1'b0);
    check1("rst_mis", misaligned_o, 1'b0);
    check32("rst_wb_data", wb_data_o, 32'h0);
    rsn_i = 1'b1;
    @(posedge clk); #1;

    // LW 0x100, gnt after 2 cycles
    op(1, 0, T_W, 0, 32'h100, 32'h0, 5'd5, 1, 2, 1, 32'hDEADBEEF, e0);
    check32("lw_be", 32'(last_be), 32'hF);
    check32("lw_addr", last_addr, 32'h100);
    check32("lw_data", last_wb_data, 32'hDEADBEEF);
    check1("lw_we", last_wb_we, 1'b1);

    // LB / LBU at 0x103
    op(1, 0, T_B, 1, 32'h103, 32'h0, 5'd6, 1, 1, 1, 32'h80ABCDEF, e0);
    check32("lb_be", 32'(last_be), 32'h8);
    check32("lb_data", last_wb_data, 32'hFFFFFF80);
    op(1, 0, T_B, 0, 32'h103, 32'h0, 5'd6, 1, 1, 2, 32'h80ABCDEF, e0);
    check32("lbu_data", last_wb_data, 32'h00000080);

    // SH 0x102
    op(0, 1, T_H, 0, 32'h102, 32'h1234ABCD, 5'd7, 1, 1, 1, 32'h0, e0);
    check32("sh_be", 32'(last_be), 32'hC);
    check32("sh_wdata", last_wdata, 32'hABCDABCD);
    check1("sh_we", last_wb_we, 1'b0);

    // LW 0x101 misaligned
    rc = req_cycles; mc = mis_count;
    op(1, 0, T_W, 0, 32'h101, 32'h0, 5'd8, 1, 1, 1, 32'h0, e0);
    check32("lw_mis_pulse", mis_count - mc, 1);
    check32("lw_mis_noreq", req_cycles - rc, 0);
    check1("lw_mis_we", last_wb_we, 1'b0);

    // Halves
    op(1, 0, T_H, 1, 32'h102, 32'h0, 5'd9, 1, 0, 1, 32'h80017FFF, e0);
    check32("lh_data", last_wb_data, 32'hFFFF8001);
    check32("lat_min", last_wb_cyc - e0 + 1, 3);
    op(1, 0, T_H, 0, 32'h100, 32'h0, 5'd9, 1, 3, 2, 32'h80017FFF, e0);
    check32("lhu_data", last_wb_data, 32'h00007FFF);

    // SB 0x101, SW with gnt+rvalid together
    op(0, 1, T_B, 0, 32'h101, 32'h000000AB, 5'd10, 1, 0, 1, 32'h0, e0);
    check32("sb_be", 32'(last_be), 32'h2);
    check32("sb_wdata", last_wdata, 32'hABABABAB);
    op(0, 1, T_W, 0, 32'h104, 32'hCAFEF00D, 5'd11, 0, 0, 0, 32'h0, e0);
    check32("sw_wdata", last_wdata, 32'hCAFEF00D);
    check32("lat_same", last_wb_cyc - e0 + 1, 2);

    // More misaligned: SH odd, LH odd
    rc = req_cycles; mc = mis_count;
    op(0, 1, T_H, 0, 32'h103, 32'h5555, 5'd12, 1, 1, 1, 32'h0, e0);
    op(1, 0, T_H, 1, 32'h101, 32'h0, 5'd13, 1, 1, 1, 32'h0, e0);
    check32("h_mis_pulses", mis_count - mc, 2);
    check32("h_mis_noreq", req_cycles - rc, 0);

    // Load with writeback disabled, then pass-throughs
    op(1, 0, T_B, 0, 32'h100, 32'h0, 5'd14, 0, 1, 1, 32'h000000F0, e0);
    check1("lb_nowe", last_wb_we, 1'b0);
    op(0, 0, T_W, 0, 32'h1234, 32'h0, 5'd3, 1, 0, 0, 32'h0, e0);
    check32("pt_data", last_wb_data, 32'h1234);
    check32("lat_pt", last_wb_cyc - e0 + 1, 1);
    op(0, 0, T_W, 0, 32'hFFFF0000, 32'h0, 5'd4, 0, 0, 0, 32'h0, e0);

    // Back-to-back pass-throughs with ex_valid kept high
    issue(0, 0, T_W, 0, 32'h11, 32'h0, 5'd1, 1, 0, 0, 32'h0, ea, go);
    issue(0, 0, T_W, 0, 32'h22, 32'h0, 5'd2, 1, 0, 0, 32'h0, eb, go);
    issue(0, 0, T_W, 0, 32'h33, 32'h0, 5'd3, 1, 0, 0, 32'h0, ec, go);
    wait_wb();
    check32("b2b_gap1", eb - ea, 2);
    check32("b2b_gap2", ec - eb, 2);

    // Reset while waiting for rvalid
    issue(1, 0, T_W, 0, 32'h200, 32'h0, 5'd7, 1, 0, 3, 32'h0, e0, go);
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    #2;
    rsn_i = 1'b0;
    exp_req.delete();
    exp_wb.delete();
    n_wb_done = n_wb_exp;
    #1;
    check1("arst_req", mem_req_o, 1'b0);
    check1("arst_wb_valid", wb_valid_o, 1'b0);
    check1("arst_wb_we", wb_we_o, 1'b0);
    check1("arst_mis", misaligned_o, 1'b0);
    check1("arst_ready", ex_ready_o, 1'b1);
    check32("arst_addr", mem_addr_o, 32'h0);
    check32("arst_wb_data", wb_data_o, 32'h0);
    check32("arst_wb_rd", 32'(wb_rd_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rsn_i = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    op(0, 0, T_W, 0, 32'h5, 32'h0, 5'd2, 1, 0, 0, 32'h0, e0);
    check32("post_rst_pt", last_wb_data, 32'h5);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
